// File: rtl/mod_counter.sv
// Up/down modulo counter with load, wrap-or-saturate at the range limits,
// a one-cycle wrap pulse and a sticky overflow flag.
module mod_counter #(
  parameter int          WIDTH = 4,
  parameter int unsigned MAX   = 2**WIDTH-1,
  parameter int          WRAP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAXV    = MAX[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam bit               WRAP_EN = (WRAP != 0);

  logic             at_max;
  logic             at_min;
  logic [WIDTH-1:0] out_nxt;
  logic             wrap_nxt;
  logic             ovf_nxt;

  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  assign at_max = (out == MAXV);
  assign at_min = (out == '0);
  assign tc     = up_dn ? at_max : at_min;

  // A limit step always sets ovf; that set overrides a simultaneous clr_ovf.
  always_comb begin
    out_nxt  = out;
    wrap_nxt = 1'b0;
    ovf_nxt  = ovf & ~clr_ovf;
    if (load) begin
      out_nxt = clamp(load_val);
    end else if (en) begin
      if (up_dn) begin
        if (at_max) begin
          ovf_nxt = 1'b1;
          if (WRAP_EN) begin
            out_nxt  = '0;
            wrap_nxt = 1'b1;
          end
        end else begin
          out_nxt = out + ONE;
        end
      end else begin
        if (at_min) begin
          ovf_nxt = 1'b1;
          if (WRAP_EN) begin
            out_nxt  = MAXV;
            wrap_nxt = 1'b1;
          end
        end else begin
          out_nxt = out - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out  <= '0;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      out  <= out_nxt;
      wrap <= wrap_nxt;
      ovf  <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench for mod_counter: a wrapping and a saturating instance
// (WIDTH=4, MAX=11) share stimulus and are checked against an integer model.
module tb_mod_counter;

  localparam int MAXC = 11;

  logic       clk;
  logic       reset;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [3:0] load_val;
  logic       clr_ovf;
  logic [3:0] out_w, out_s;
  logic       tc_w, tc_s, wrap_w, wrap_s, ovf_w, ovf_s;

  mod_counter #(.WIDTH(4), .MAX(MAXC), .WRAP(1)) u_wrap (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .clr_ovf(clr_ovf),
    .out(out_w), .tc(tc_w), .wrap(wrap_w), .ovf(ovf_w)
  );

  mod_counter #(.WIDTH(4), .MAX(MAXC), .WRAP(0)) u_sat (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .clr_ovf(clr_ovf),
    .out(out_s), .tc(tc_s), .wrap(wrap_s), .ovf(ovf_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] out_w;
    logic       wrap_w;
    logic       ovf_w;
    logic       tc_w;
    logic [3:0] out_s;
    logic       wrap_s;
    logic       ovf_s;
    logic       tc_s;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference state: index 0 = wrapping counter, index 1 = saturating counter.
  int m_out[2];
  bit m_wrap[2];
  bit m_ovf[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("wrap_dut.out",  32'(out_w),  32'(e.out_w));
      chk("wrap_dut.wrap", 32'(wrap_w), 32'(e.wrap_w));
      chk("wrap_dut.ovf",  32'(ovf_w),  32'(e.ovf_w));
      chk("wrap_dut.tc",   32'(tc_w),   32'(e.tc_w));
      chk("sat_dut.out",   32'(out_s),  32'(e.out_s));
      chk("sat_dut.wrap",  32'(wrap_s), 32'(e.wrap_s));
      chk("sat_dut.ovf",   32'(ovf_s),  32'(e.ovf_s));
      chk("sat_dut.tc",    32'(tc_s),   32'(e.tc_s));
    end
  end

  function automatic void model_clear();
    for (int i = 0; i < 2; i++) begin
      m_out[i] = 0; m_wrap[i] = 1'b0; m_ovf[i] = 1'b0;
    end
  endfunction

  // One rising edge of behaviour: integer next value, then range handling.
  function automatic void model_edge(bit e, bit up, bit ld, int lv, bit clr);
    for (int i = 0; i < 2; i++) begin
      bit wraps = (i == 0);
      int tgt;
      m_wrap[i] = 1'b0;
      if (ld) begin
        m_out[i] = (lv > MAXC) ? MAXC : lv;
        m_ovf[i] = m_ovf[i] && !clr;
      end else if (e) begin
        tgt = up ? m_out[i] + 1 : m_out[i] - 1;
        if (tgt > MAXC || tgt < 0) begin
          m_ovf[i] = 1'b1;
          if (wraps) begin
            m_out[i]  = (tgt < 0) ? MAXC : 0;
            m_wrap[i] = 1'b1;
          end
        end else begin
          m_out[i] = tgt;
          m_ovf[i] = m_ovf[i] && !clr;
        end
      end else begin
        m_ovf[i] = m_ovf[i] && !clr;
      end
    end
  endfunction

  function automatic void push_expect(bit up);
    exp_t e;
    e.out_w  = 4'(m_out[0]);
    e.wrap_w = m_wrap[0];
    e.ovf_w  = m_ovf[0];
    e.tc_w   = up ? (m_out[0] == MAXC) : (m_out[0] == 0);
    e.out_s  = 4'(m_out[1]);
    e.wrap_s = m_wrap[1];
    e.ovf_s  = m_ovf[1];
    e.tc_s   = up ? (m_out[1] == MAXC) : (m_out[1] == 0);
    q.push_back(e);
  endfunction

  // Called just after a rising edge: drive inputs, queue the expectation
  // for the state visible before the next edge, then take that edge.
  task automatic step(input bit e, input bit up, input bit ld, input int lv, input bit clr);
    en = e; up_dn = up; load = ld; load_val = 4'(lv); clr_ovf = clr;
    push_expect(up);
    @(posedge clk);
    if (reset) model_edge(e, up, ld, lv, clr);
    #1;
  endtask

  // Asserts reset between edges and holds it over an edge with live inputs.
  task automatic mid_reset();
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    en = 1'b1; up_dn = 1'b1; load = 1'b1; load_val = 4'd9; clr_ovf = 1'b0;
    push_expect(1'b1);
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    reset = 1'b1;
  endtask

  initial begin
    bit dir;
    reset = 1'b0;
    en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0; clr_ovf = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    step(1'b1, 1'b1, 1'b1, 7, 1'b0);
    reset = 1'b1;

    // Twelve up edges: full run then rollover
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 0, 1'b0);
    // Reload both to 0, then one down edge from 0
    step(1'b0, 1'b1, 1'b1, 0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 0, 1'b0);
    // Fifteen up edges from 0, then fourteen down
    step(1'b0, 1'b1, 1'b1, 0, 1'b1);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 1'b0, 0, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 0, 1'b0);
    // Load wins over enable; out-of-range load clamps
    step(1'b1, 1'b1, 1'b1, 7, 1'b0);
    step(1'b1, 1'b0, 1'b1, 14, 1'b0);
    step(1'b0, 1'b1, 1'b0, 0, 1'b0);
    // clr_ovf loses to a simultaneous wrap, then clears
    step(1'b0, 1'b1, 1'b1, 0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 11, 1'b0);
    step(1'b1, 1'b1, 1'b0, 0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 0, 1'b0);
    // Asynchronous reset at out=5 with ovf set
    step(1'b1, 1'b1, 1'b0, 0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 5, 1'b0);
    step(1'b0, 1'b1, 1'b0, 0, 1'b0);
    mid_reset();
    step(1'b1, 1'b1, 1'b0, 0, 1'b0);

    // Randomized traffic with direction runs and occasional resets
    dir = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) dir = ~dir;
      if ($urandom_range(0, 79) == 0) begin
        mid_reset();
      end else begin
        step($urandom_range(0, 3) != 0, dir, $urandom_range(0, 11) == 0,
             int'($urandom_range(0, 15)), $urandom_range(0, 5) == 0);
      end
    end
    step(1'b0, 1'b1, 1'b0, 0, 1'b0);

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
